slap_video_mixer: RTL and testbench

- Downstream consumer of the sprite layer's 8-bit line-buffer pixel.
- Aligns the sprite pixel to the background and foreground tile pixels, resolves layer priority and transparency, and applies blanking.
- Looks the winning colour index up in the RGB colour PROMs (held in downloadable block RAM) and produces registered 4-bit R/G/B for the video output stage.
- Runs on master_clk with a pixel clock-enable.

---
 rtl/slap_video_mixer.sv | 176 +++++++++++++++++
 tb/tb_slap_video_mixer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slap_video_mixer.sv
// slap_video_mixer: aligns the delayed sprite pixel with the background and
// foreground tile pixels. It then resolves layer priority and transparency,
// looks the winning index up in the downloadable RGB colour PROMs, and
// registers blanked 4-bit RGB for the video output stage.
module slap_video_mixer #(
  parameter int SPR_DELAY = 2,
  parameter int PAL_AW    = 8
) (
  input  logic       master_clk,
  input  logic       reset,
  input  logic       pixel_ce,
  input  logic [7:0] spr_pix,
  input  logic [7:0] bg_pix,
  input  logic [7:0] fg_pix,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [2:0] layer_en,
  input  logic [9:0] dn_addr,
  input  logic [7:0] dn_data,
  input  logic       dn_wr,
  input  logic       prom_cs,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hblank_o,
  output logic       vblank_o
);

  localparam int PAL_DEPTH = 1 << PAL_AW;

  logic [7:0] spr_delayed;

  // stage 1 registers (layer-enable masked pixels and blank flags)
  logic [7:0] s1_spr;
  logic [7:0] s1_bg;
  logic [7:0] s1_fg;
  logic       s1_hb;
  logic       s1_vb;

  // stage 2 registers (winning palette index)
  logic [PAL_AW-1:0] s2_index;
  logic              s2_hb;
  logic              s2_vb;
  logic [7:0]        sel_pix;

  // stage 3 registers (palette read data)
  logic [3:0] rd_r;
  logic [3:0] rd_g;
  logic [3:0] rd_b;
  logic       s3_hb;
  logic       s3_vb;

  // colour PROM images, loaded through the download port
  logic [3:0] pal_r [PAL_DEPTH];
  logic [3:0] pal_g [PAL_DEPTH];
  logic [3:0] pal_b [PAL_DEPTH];

  logic              wr_en;
  logic [PAL_AW-1:0] wr_addr;

  assign wr_en   = dn_wr & prom_cs & (dn_addr[9:8] != 2'd3);
  assign wr_addr = dn_addr[PAL_AW-1:0];

  generate
    if (SPR_DELAY == 0) begin : g_no_delay
      assign spr_delayed = spr_pix;
    end else begin : g_delay
      logic [7:0] dly_q [SPR_DELAY];

      // shift the sprite pixel one slot per pixel tick so it lines up with the tile layers
      always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SPR_DELAY; i++) dly_q[i] <= 8'h00;
        end else if (pixel_ce) begin
          dly_q[0] <= spr_pix;
          for (int i = 1; i < SPR_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign spr_delayed = dly_q[SPR_DELAY-1];
    end
  endgenerate

  // capture the aligned layers, forcing disabled layers to transparent zero
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      s1_spr <= 8'h00;
      s1_bg  <= 8'h00;
      s1_fg  <= 8'h00;
      s1_hb  <= 1'b0;
      s1_vb  <= 1'b0;
    end else if (pixel_ce) begin
      s1_spr <= layer_en[1] ? spr_delayed : 8'h00;
      s1_bg  <= layer_en[0] ? bg_pix      : 8'h00;
      s1_fg  <= layer_en[2] ? fg_pix      : 8'h00;
      s1_hb  <= hblank;
      s1_vb  <= vblank;
    end
  end

  // priority: opaque foreground beats opaque sprite, background is the fallback
  always_comb begin
    sel_pix = s1_bg;
    if (s1_fg[3:0] != 4'h0) begin
      sel_pix = s1_fg;
    end else if (s1_spr[3:0] != 4'h0) begin
      sel_pix = s1_spr;
    end
  end

  // register the winning index and carry the blank flags alongside
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      s2_index <= '0;
      s2_hb    <= 1'b0;
      s2_vb    <= 1'b0;
    end else if (pixel_ce) begin
      s2_index <= sel_pix[PAL_AW-1:0];
      s2_hb    <= s1_hb;
      s2_vb    <= s1_vb;
    end
  end

  // download write port; independent of the pixel read port
  always_ff @(posedge master_clk) begin
    if (wr_en) begin
      case (dn_addr[9:8])
        2'd0:    pal_r[wr_addr] <= dn_data[3:0];
        2'd1:    pal_g[wr_addr] <= dn_data[3:0];
        2'd2:    pal_b[wr_addr] <= dn_data[3:0];
        default: ;
      endcase
    end
  end

  // synchronous palette read; a same-cycle write to the entry yields the old colour
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      rd_r  <= 4'h0;
      rd_g  <= 4'h0;
      rd_b  <= 4'h0;
      s3_hb <= 1'b0;
      s3_vb <= 1'b0;
    end else if (pixel_ce) begin
      rd_r  <= pal_r[s2_index];
      rd_g  <= pal_g[s2_index];
      rd_b  <= pal_b[s2_index];
      s3_hb <= s2_hb;
      s3_vb <= s2_vb;
    end
  end

  // output register with blanking; blank outputs idle high while in reset
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      red      <= 4'h0;
      green    <= 4'h0;
      blue     <= 4'h0;
      hblank_o <= 1'b1;
      vblank_o <= 1'b1;
    end else if (pixel_ce) begin
      if (s3_hb | s3_vb) begin
        red   <= 4'h0;
        green <= 4'h0;
        blue  <= 4'h0;
      end else begin
        red   <= rd_r;
        green <= rd_g;
        blue  <= rd_b;
      end
      hblank_o <= s3_hb;
      vblank_o <= s3_vb;
    end
  end

endmodule

// File: tb/tb_slap_video_mixer.sv
// tb_slap_video_mixer: directed and randomized checks of the video mixer
// against a tick-indexed reference model of layer priority, blanking and
// palette lookup.
module tb_slap_video_mixer;

  localparam int SPR_DELAY = 2;
  localparam int PAL_AW    = 8;
  localparam int MAXT      = 4096;

  logic       master_clk = 1'b0;
  logic       reset      = 1'b0;
  logic       pixel_ce   = 1'b0;
  logic [7:0] spr_pix    = 8'h00;
  logic [7:0] bg_pix     = 8'h00;
  logic [7:0] fg_pix     = 8'h00;
  logic       hblank     = 1'b0;
  logic       vblank     = 1'b0;
  logic [2:0] layer_en   = 3'b111;
  logic [9:0] dn_addr    = 10'h000;
  logic [7:0] dn_data    = 8'h00;
  logic       dn_wr      = 1'b0;
  logic       prom_cs    = 1'b0;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hblank_o;
  logic       vblank_o;

  always #5 master_clk = ~master_clk;

  slap_video_mixer #(
    .SPR_DELAY(SPR_DELAY),
    .PAL_AW   (PAL_AW)
  ) dut (
    .master_clk(master_clk),
    .reset     (reset),
    .pixel_ce  (pixel_ce),
    .spr_pix   (spr_pix),
    .bg_pix    (bg_pix),
    .fg_pix    (fg_pix),
    .hblank    (hblank),
    .vblank    (vblank),
    .layer_en  (layer_en),
    .dn_addr   (dn_addr),
    .dn_data   (dn_data),
    .dn_wr     (dn_wr),
    .prom_cs   (prom_cs),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hblank_o  (hblank_o),
    .vblank_o  (vblank_o)
  );

  int total = 0;
  int bad   = 0;

  // reference model state: every pixel tick is a numbered record
  int         k    = 0;
  int         base = 0;
  logic [7:0] rec_spr [MAXT];
  logic [7:0] rec_bg  [MAXT];
  logic [7:0] rec_fg  [MAXT];
  logic [2:0] rec_en  [MAXT];
  logic       rec_hb  [MAXT];
  logic       rec_vb  [MAXT];
  logic [11:0] lut    [MAXT];
  logic [3:0] pal_r [256];
  logic [3:0] pal_g [256];
  logic [3:0] pal_b [256];
  logic [13:0] exp_last = 14'h3000;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h (tick %0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [13:0] observed();
    return {hblank_o, vblank_o, red, green, blue};
  endfunction

  function automatic logic [11:0] rgb();
    return {red, green, blue};
  endfunction

  // palette index a record produces under the layer rules; records from before reset are all zero
  function automatic logic [7:0] mix_index(input int j);
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] f;
    if (j <= base) return 8'h00;
    b = rec_en[j][0] ? rec_bg[j] : 8'h00;
    f = rec_en[j][2] ? rec_fg[j] : 8'h00;
    s = 8'h00;
    if (j - SPR_DELAY > base) s = rec_spr[j-SPR_DELAY];
    if (!rec_en[j][1]) s = 8'h00;
    if (f[3:0] != 4'h0) return f;
    if (s[3:0] != 4'h0) return s;
    return b;
  endfunction

  function automatic logic [1:0] rec_blank(input int j);
    if (j <= base) return 2'b00;
    return {rec_hb[j], rec_vb[j]};
  endfunction

  function automatic void model_write(input logic [9:0] a, input logic [7:0] d, input logic cs, input logic wr);
    if (wr && cs) begin
      case (a[9:8])
        2'd0:    pal_r[a[7:0]] = d[3:0];
        2'd1:    pal_g[a[7:0]] = d[3:0];
        2'd2:    pal_b[a[7:0]] = d[3:0];
        default: ;
      endcase
    end
  endfunction

  function automatic logic [7:0] rnd_pix();
    logic [7:0] v;
    v = 8'($urandom);
    if ($urandom_range(2) == 0) v[3:0] = 4'h0;
    return v;
  endfunction

  task automatic do_write(input logic [9:0] a, input logic [7:0] d, input logic cs);
    @(negedge master_clk);
    dn_addr = a;
    dn_data = d;
    prom_cs = cs;
    dn_wr   = 1'b1;
    @(negedge master_clk);
    dn_wr = 1'b0;
    model_write(a, d, cs, 1'b1);
  endtask

  // one pixel tick after some idle clocks, optionally with a download write on the same edge
  task automatic applyStimulus(input logic [7:0] spr, input logic [7:0] bg, input logic [7:0] fg,
                               input logic hb, input logic vb, input logic [2:0] en,
                               input logic wr, input logic [9:0] wa, input logic [7:0] wd,
                               input logic wcs, input int idle);
    logic [7:0]  idx;
    logic [1:0]  bl;
    logic [13:0] exp;
    repeat (idle) @(negedge master_clk);
    checkOutput("hold", 32'(observed()), 32'(exp_last));
    spr_pix  = spr;
    bg_pix   = bg;
    fg_pix   = fg;
    hblank   = hb;
    vblank   = vb;
    layer_en = en;
    dn_addr  = wa;
    dn_data  = wd;
    prom_cs  = wcs;
    dn_wr    = wr;
    pixel_ce = 1'b1;
    @(negedge master_clk);
    pixel_ce = 1'b0;
    dn_wr    = 1'b0;
    k++;
    rec_spr[k] = spr;
    rec_bg[k]  = bg;
    rec_fg[k]  = fg;
    rec_en[k]  = en;
    rec_hb[k]  = hb;
    rec_vb[k]  = vb;
    idx = mix_index(k - 2);
    lut[k] = {pal_r[idx], pal_g[idx], pal_b[idx]};
    model_write(wa, wd, wcs, wr);
    if (k - base == 1) begin
      exp = 14'h0000;
    end else begin
      bl  = rec_blank(k - 3);
      exp = {bl, (bl != 2'b00) ? 12'h000 : lut[k-1]};
    end
    checkOutput("pixel", 32'(observed()), 32'(exp));
    exp_last = exp;
  endtask

  task automatic pix(input logic [7:0] spr, input logic [7:0] bg, input logic [7:0] fg,
                     input logic hb, input logic vb, input logic [2:0] en);
    applyStimulus(spr, bg, fg, hb, vb, en, 1'b0, 10'h000, 8'h00, 1'b0, 3);
  endtask

  // reset asserted between clock edges while pixel_ce is high
  task automatic resetMid(input logic [7:0] spr, input logic [7:0] bg);
    @(negedge master_clk);
    spr_pix  = spr;
    bg_pix   = bg;
    pixel_ce = 1'b1;
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", 32'(observed()), 32'h3000);
    @(negedge master_clk);
    pixel_ce = 1'b0;
    repeat (2) @(negedge master_clk);
    reset    = 1'b0;
    base     = k;
    exp_last = 14'h3000;
  endtask

  initial begin
    logic [3:0] v;
    logic [2:0] en;
    #3 reset = 1'b1;
    #1 checkOutput("reset_state", 32'(observed()), 32'h3000);
    repeat (3) @(negedge master_clk);
    reset = 1'b0;

    // fill every palette entry, with the directed colours at known indices
    for (int i = 0; i < 256; i++) begin
      for (int p = 0; p < 3; p++) begin
        v = 4'($urandom);
        if (i == 8'h25) v = (p == 0) ? 4'hA : (p == 1) ? 4'h5 : 4'h3;
        if (i == 8'h41) v = (p == 0) ? 4'h1 : (p == 1) ? 4'h2 : 4'h3;
        if (i == 8'h17) v = 4'hF;
        do_write({2'(p), 8'(i)}, {4'($urandom), v}, 1'b1);
      end
    end

    // background only
    repeat (4) pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("bg_only", 32'(rgb()), 32'hA53);

    // a single opaque sprite pixel lands on the background pixel two ticks later
    pix(8'h41, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    repeat (5) pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("spr_align", 32'(rgb()), 32'h123);
    pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("spr_neighbour", 32'(rgb()), 32'hA53);

    repeat (6) pix(8'h40, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("spr_transparent", 32'(rgb()), 32'hA53);

    // layer priority and debug enables
    repeat (6) pix(8'h41, 8'h25, 8'h17, 1'b0, 1'b0, 3'b111);
    checkOutput("fg_wins", 32'(rgb()), 32'hFFF);
    repeat (6) pix(8'h41, 8'h25, 8'h17, 1'b0, 1'b0, 3'b011);
    checkOutput("fg_disabled", 32'(rgb()), 32'h123);
    repeat (6) pix(8'h41, 8'h25, 8'h17, 1'b0, 1'b0, 3'b001);
    checkOutput("spr_disabled", 32'(rgb()), 32'hA53);

    // one blanked pixel between opaque neighbours
    repeat (4) pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    pix(8'h00, 8'h25, 8'h00, 1'b1, 1'b0, 3'b111);
    repeat (2) pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("hb_before", 32'(observed()), 32'h0A53);
    pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("hb_pixel", 32'(observed()), 32'h2000);
    pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("hb_after", 32'(observed()), 32'h0A53);

    // writes that must not reach the palette
    do_write(10'h325, 8'h00, 1'b1);
    do_write(10'h025, 8'h00, 1'b0);
    do_write(10'h225, 8'hF0, 1'b0);
    repeat (4) pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("no_write", 32'(rgb()), 32'hA53);

    // write to the displayed entry on the same edge as its read
    applyStimulus(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111, 1'b1, 10'h025, 8'h07, 1'b1, 3);
    pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("rdw_old", 32'(rgb()), 32'hA53);
    pix(8'h00, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("rdw_new", 32'(rgb()), 32'h753);
    do_write(10'h025, 8'h0A, 1'b1);

    // reset mid-stream, palette survives, pipeline refills
    pix(8'h41, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    resetMid(8'h41, 8'h25);
    repeat (4) pix(8'h41, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("rst_first_bg", 32'(rgb()), 32'hA53);
    repeat (2) pix(8'h41, 8'h25, 8'h00, 1'b0, 1'b0, 3'b111);
    checkOutput("rst_first_spr", 32'(rgb()), 32'h123);

    // randomized traffic with interleaved and same-edge downloads
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b111;
      if ($urandom_range(7) == 0)
        do_write(10'($urandom), 8'($urandom), ($urandom_range(3) != 0));
      if (i == 200) resetMid(rnd_pix(), rnd_pix());
      applyStimulus(rnd_pix(), rnd_pix(), rnd_pix(),
                    ($urandom_range(9) == 0), ($urandom_range(15) == 0), en,
                    ($urandom_range(5) == 0), 10'($urandom), 8'($urandom), 1'b1,
                    $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
